// File: rtl/seq_sched_pkg.sv
// Shared types and default sizing for the sequential-circuit scheduler.
package seq_sched_pkg;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_FRAME_LEN = 8;

    typedef enum logic [1:0] {IDLE, CLR, SHIFT, DONE} state_t;

    typedef logic [DEF_FRAME_LEN-1:0] frame_t;

endpackage

// File: rtl/seq_circuit_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] winner,
    output logic             found
);

    int               idx;
    logic [IDX_W-1:0] sel;

    always_comb begin
        gnt    = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        sel    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            sel = IDX_W'(idx);
            if (!found && req[sel]) begin
                found    = 1'b1;
                gnt[sel] = 1'b1;
                winner   = sel;
            end
        end
    end

endmodule

// File: rtl/seq_circuit_scheduler.sv
// Time-shares one serial sequential circuit among N_REQ requesters: grant,
// clear the circuit, shift a frame through it LSB first, report the result.
module seq_circuit_scheduler
    import seq_sched_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int IDX_W     = $clog2(N_REQ),
    parameter int CNT_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*FRAME_LEN-1:0] req_frame,
    input  logic                       abort,
    output logic [N_REQ-1:0]           gnt,
    output logic                       busy,
    output logic                       circ_reset,
    output logic                       circ_x,
    input  logic                       circ_y,
    input  logic                       circ_q,
    output logic                       done,
    output logic [FRAME_LEN-1:0]       result,
    output logic [IDX_W-1:0]           done_id,
    output logic                       final_q
);

    state_t               state;
    state_t               state_nx;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     owner;
    logic [IDX_W-1:0]     win;
    logic [N_REQ-1:0]     arb_gnt;
    logic                 arb_found;
    logic [FRAME_LEN-1:0] frame_sr;
    logic [CNT_W-1:0]     cnt;
    logic                 abort_clr;
    logic                 grant;
    logic                 grant_ok;
    logic                 last_bit;
    logic                 abort_hit;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req    (req),
        .ptr    (ptr),
        .gnt    (arb_gnt),
        .winner (win),
        .found  (arb_found)
    );

    always_comb begin
        state_nx  = state;
        grant     = 1'b0;
        abort_hit = 1'b0;
        last_bit  = (cnt == CNT_W'(FRAME_LEN - 1));
        case (state)
            IDLE: begin
                if (arb_found) begin
                    grant    = 1'b1;
                    state_nx = CLR;
                end
            end
            CLR: begin
                if (abort) begin
                    abort_hit = 1'b1;
                    state_nx  = IDLE;
                end else begin
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    abort_hit = 1'b1;
                    state_nx  = IDLE;
                end else if (last_bit) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The grant is a Mealy pulse off the arbiter, so it must be masked while reset is held.
    assign grant_ok   = grant & reset;
    assign gnt        = grant_ok ? arb_gnt : '0;
    assign busy       = (state != IDLE) | grant_ok;
    assign circ_reset = (state == CLR) | abort_clr;
    assign circ_x     = (state == SHIFT) & frame_sr[0];
    assign done       = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            frame_sr  <= '0;
            cnt       <= '0;
            abort_clr <= 1'b0;
            result    <= '0;
            done_id   <= '0;
            final_q   <= 1'b0;
        end else begin
            state     <= state_nx;
            abort_clr <= abort_hit;
            if (grant) begin
                ptr      <= (win == IDX_W'(N_REQ - 1)) ? '0 : win + 1'b1;
                owner    <= win;
                frame_sr <= req_frame[int'(win)*FRAME_LEN +: FRAME_LEN];
            end
            if (state == CLR && !abort) begin
                result <= '0;
                cnt    <= '0;
            end
            // An aborted SHIFT cycle leaves result exactly as far as it got.
            if (state == SHIFT && !abort) begin
                result[cnt] <= circ_y;
                frame_sr    <= frame_sr >> 1;
                cnt         <= cnt + 1'b1;
                if (last_bit) begin
                    final_q <= circ_q;
                    done_id <= owner;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_circuit_scheduler.sv
// Bench for seq_circuit_scheduler: schedule-level reference model checked every
// cycle, plus literal expectations on the logged grants and completions.
module tb_seq_circuit_scheduler;

    localparam int N  = 4;
    localparam int FL = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_frame;
    logic        abort;
    logic [3:0]  gnt;
    logic        busy;
    logic        circ_reset;
    logic        circ_x;
    logic        circ_y;
    logic        circ_q;
    logic        done;
    logic [7:0]  result;
    logic [1:0]  done_id;
    logic        final_q;

    logic [3:0]  oneshot;
    logic        use_real;
    logic        tq = 1'b0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    int g_cyc[$];
    int g_idx[$];
    int d_cyc[$];
    int d_res[$];
    int d_id[$];
    int d_fq[$];

    seq_circuit_scheduler #(
        .N_REQ     (N),
        .FRAME_LEN (FL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_frame  (req_frame),
        .abort      (abort),
        .gnt        (gnt),
        .busy       (busy),
        .circ_reset (circ_reset),
        .circ_x     (circ_x),
        .circ_y     (circ_y),
        .circ_q     (circ_q),
        .done       (done),
        .result     (result),
        .done_id    (done_id),
        .final_q    (final_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Shared circuit: a toggle cell, q flips on x=1, y = x ^ q (Mealy); stub is y = x.
    always @(posedge clk) begin
        if (circ_reset) tq <= 1'b0;
        else            tq <= tq ^ circ_x;
    end
    assign circ_y = use_real ? (circ_x ^ tq) : circ_x;
    assign circ_q = use_real ? tq : 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    // Result word and final state for one frame pushed LSB first through the chosen circuit.
    function automatic void circ_fn(input logic [7:0] f, input logic real_c,
                                    output logic [7:0] r, output logic fq);
        logic q;
        logic xb;
        logic [7:0] fs;
        q  = 1'b0;
        r  = 8'h00;
        fq = 1'b0;
        fs = f;
        for (int i = 0; i < FL; i++) begin
            xb = fs[0];
            fs = fs >> 1;
            if (real_c) begin
                r = {xb ^ q, r[7:1]};
                fq = q;
                q = q ^ xb;
            end else begin
                r = {xb, r[7:1]};
            end
        end
    endfunction

    // Reference: a job granted at cycle G clears at G+1, shifts at G+2..G+1+FL, completes at G+2+FL.
    bit         m_active;
    int         m_g;
    int         m_owner;
    int         m_ptr;
    int         m_id;
    logic [7:0] m_frame;
    logic [7:0] m_jres;
    logic [7:0] m_res;
    logic       m_jfq;
    logic       m_fq;
    logic       m_abpend;

    initial begin
        logic [3:0] e_gnt;
        logic       e_busy, e_cr, e_x, e_done, hold_ok;
        int         pick, d, idx;
        forever begin
            @(negedge clk);
            e_gnt = '0; e_busy = 0; e_cr = 0; e_x = 0; e_done = 0;
            hold_ok = 1; pick = -1; d = 0;
            if (!reset) begin
                m_active = 0; m_ptr = 0; m_abpend = 0;
                m_res = 8'h00; m_id = 0; m_fq = 1'b0;
            end else begin
                e_cr = m_abpend;
                if (m_active) begin
                    d = cyc - m_g;
                    e_busy = 1;
                    if (d == 1) e_cr = 1;
                    if (d >= 2 && d <= FL + 1) begin
                        e_x = |(m_frame & 8'(1 << (d - 2)));
                        hold_ok = 0;
                    end
                    if (d == FL + 2) e_done = 1;
                end else begin
                    for (int k = 0; k < N; k++) begin
                        idx = (m_ptr + k) % N;
                        if (pick < 0 && ((req >> idx) & 4'b0001) != 4'b0000) pick = idx;
                    end
                    if (pick >= 0) begin
                        e_gnt = 4'(1 << pick);
                        e_busy = 1;
                    end
                end
            end
            chk("gnt", 32'(gnt), 32'(e_gnt));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("circ_reset", 32'(circ_reset), 32'(e_cr));
            chk("circ_x", 32'(circ_x), 32'(e_x));
            chk("done", 32'(done), 32'(e_done));
            if (hold_ok) begin
                chk("result", 32'(result), 32'(m_res));
                chk("done_id", 32'(done_id), 32'(m_id));
                chk("final_q", 32'(final_q), 32'(m_fq));
            end
            if (reset && gnt != 4'b0000) begin
                g_cyc.push_back(cyc);
                for (int k = 0; k < N; k++)
                    if (gnt == 4'(1 << k)) g_idx.push_back(k);
            end
            if (reset && done) begin
                d_cyc.push_back(cyc);
                d_res.push_back(int'(result));
                d_id.push_back(int'(done_id));
                d_fq.push_back(int'(final_q));
            end
            if (reset) begin
                m_abpend = 0;
                if (m_active) begin
                    if (abort && d >= 1 && d <= FL + 1) begin
                        m_active = 0;
                        m_abpend = 1;
                        if (d >= 2) m_res = m_jres & 8'((1 << (d - 2)) - 1);
                    end else if (d == FL + 1) begin
                        m_res = m_jres; m_id = m_owner; m_fq = m_jfq;
                    end else if (d == FL + 2) begin
                        m_active = 0;
                    end
                end else if (pick >= 0) begin
                    m_active = 1;
                    m_g = cyc;
                    m_owner = pick;
                    m_frame = 8'(req_frame >> (pick * FL));
                    circ_fn(m_frame, use_real, m_jres, m_jfq);
                    m_ptr = (pick + 1) % N;
                end
            end
        end
    end

    task automatic step();
        logic [3:0] g;
        @(negedge clk);
        g = gnt;
        @(posedge clk);
        #1;
        req = req & ~(g & oneshot);
    endtask

    task automatic set_frame(input int i, input logic [7:0] v);
        req_frame = (req_frame & ~(32'hFF << (i * FL))) | (32'(v) << (i * FL));
    endtask

    task automatic clear_logs();
        g_cyc.delete(); g_idx.delete(); d_cyc.delete();
        d_res.delete(); d_id.delete(); d_fq.delete();
    endtask

    initial begin
        int exp_b[6];
        exp_b = '{0, 1, 2, 3, 0, 3};
        reset = 1'b0; req = 4'h0; req_frame = 32'h0; abort = 1'b0;
        oneshot = 4'hF; use_real = 1'b0;
        @(posedge clk); #1;
        repeat (3) step();
        reset = 1'b1;
        step(); step();

        // Fairness: all four held, then only 0 and 3
        clear_logs();
        req_frame = {8'h69, 8'h96, 8'hC3, 8'h3C};
        req = 4'hF; oneshot = 4'h0;
        repeat (44) step();
        req = 4'b1001; oneshot = 4'hF;
        repeat (26) step();
        chk("fair_count", 32'(g_idx.size()), 32'd6);
        for (int i = 0; i < 6; i++) chk("fair_order", 32'(qget(g_idx, i)), 32'(exp_b[i]));
        for (int i = 1; i < 6; i++)
            chk("fair_gap", 32'(qget(g_cyc, i) - qget(g_cyc, i - 1)), 32'd11);

        // Single frame from requester 1
        clear_logs();
        set_frame(1, 8'hA5);
        req = 4'b0010;
        repeat (14) step();
        chk("single_gidx", 32'(qget(g_idx, 0)), 32'd1);
        chk("single_latency", 32'(qget(d_cyc, 0) - qget(g_cyc, 0)), 32'd10);
        chk("single_result", 32'(qget(d_res, 0)), 32'hA5);
        chk("single_id", 32'(qget(d_id, 0)), 32'd1);

        // Abort in CLR with nothing pending
        clear_logs();
        set_frame(0, 8'hFF);
        req = 4'b0001;
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("clr_abort_busy", 32'(busy), 32'd0);
        chk("clr_abort_creset", 32'(circ_reset), 32'd1);
        chk("clr_abort_result", 32'(result), 32'hA5);
        repeat (3) step();
        chk("clr_abort_nodone", 32'(d_cyc.size()), 32'd0);

        // Abort at SHIFT cnt=3 with requester 2 pending
        clear_logs();
        set_frame(1, 8'hF7); set_frame(2, 8'h3A);
        req = 4'b0110;
        repeat (5) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_next_gnt", 32'(gnt), 32'h4);
        chk("abort_partial", 32'(result), 32'h07);
        chk("abort_creset", 32'(circ_reset), 32'd1);
        repeat (16) step();
        chk("abort_g0", 32'(qget(g_idx, 0)), 32'd1);
        chk("abort_g1", 32'(qget(g_idx, 1)), 32'd2);
        chk("abort_gap", 32'(qget(g_cyc, 1) - qget(g_cyc, 0)), 32'd6);
        chk("abort_dcount", 32'(d_cyc.size()), 32'd1);
        chk("abort_did", 32'(qget(d_id, 0)), 32'd2);
        chk("abort_dres", 32'(qget(d_res, 0)), 32'h3A);

        // Back-to-back from requester 3; abort during the idle grant is ignored
        clear_logs();
        set_frame(3, 8'h81);
        req = 4'b1000; oneshot = 4'b0111; abort = 1'b1;
        step();
        abort = 1'b0;
        set_frame(3, 8'h7E);
        repeat (10) step();
        oneshot = 4'hF;
        chk("b2b_gnt", 32'(gnt), 32'h8);
        chk("b2b_hold_g", 32'(result), 32'h81);
        step();
        chk("b2b_hold_clr", 32'(result), 32'h81);
        repeat (12) step();
        chk("b2b_gap", 32'(qget(g_cyc, 1) - qget(g_cyc, 0)), 32'd11);
        chk("b2b_dcount", 32'(d_cyc.size()), 32'd2);
        chk("b2b_res0", 32'(qget(d_res, 0)), 32'h81);
        chk("b2b_res1", 32'(qget(d_res, 1)), 32'h7E);

        // Real toggle circuit, frame 8'h55
        clear_logs();
        use_real = 1'b1;
        set_frame(0, 8'h55);
        req = 4'b0001;
        repeat (14) step();
        use_real = 1'b0;
        chk("real_result", 32'(qget(d_res, 0)), 32'h33);
        chk("real_final_q", 32'(qget(d_fq, 0)), 32'd0);
        chk("real_id", 32'(qget(d_id, 0)), 32'd0);

        // Asynchronous reset in the middle of SHIFT
        clear_logs();
        set_frame(1, 8'hA5);
        req = 4'b0010;
        repeat (5) step();
        #2 reset = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_creset", 32'(circ_reset), 32'd0);
        chk("rst_x", 32'(circ_x), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_id", 32'(done_id), 32'd0);
        chk("rst_fq", 32'(final_q), 32'd0);
        req = 4'hF; oneshot = 4'hF;
        req_frame = {8'h0F, 8'hF0, 8'h5A, 8'hA5};
        step(); step();
        chk("rst_held_gnt", 32'(gnt), 32'd0);
        clear_logs();
        reset = 1'b1;
        #1;
        chk("rst_first_gnt", 32'(gnt), 32'h1);
        repeat (48) step();
        chk("rst_count", 32'(g_idx.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("rst_order", 32'(qget(g_idx, i)), 32'(i));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
